// File: rtl/fetch_bundle.sv
// Fetch stage: generates bundle PCs, issues fixed-latency imem reads, and buffers bundles for decode.
// Optional perf counters enabled by defining FETCH_PERF_COUNTERS_EN.
module fetch_bundle #(
  parameter int unsigned SUPER_SCALAR_WIDTH = 2,
  parameter int unsigned WORD_WIDTH         = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned IMEM_LATENCY       = 2,
  parameter int unsigned FIFO_DEPTH         = 4
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  output logic                                     imem_req_out,
  output logic [WORD_WIDTH-1:0]                    imem_addr_out,
  input  logic [SUPER_SCALAR_WIDTH*WORD_WIDTH-1:0] imem_data_in,
  input  logic                                     redirect_valid_in,
  input  logic [WORD_WIDTH-1:0]                    redirect_pc_in,
  input  logic                                     decode_ready_in,
  output logic                                     decode_valid_out,
  output logic [SUPER_SCALAR_WIDTH*WORD_WIDTH-1:0] decode_instr_out,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [31:0]                              perf_stall_cycles_out,
  output logic [31:0]                              perf_squashed_out,
`endif
  output logic [SUPER_SCALAR_WIDTH*WORD_WIDTH-1:0] decode_pc_out
);

  localparam int unsigned BW = SUPER_SCALAR_WIDTH * WORD_WIDTH;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [WORD_WIDTH-1:0] PC_STEP = WORD_WIDTH'(SUPER_SCALAR_WIDTH * 4);

  logic [WORD_WIDTH-1:0]   r_pc;
  logic [IMEM_LATENCY-1:0] r_sr_vld;
  logic [WORD_WIDTH-1:0]   r_sr_pc [IMEM_LATENCY];
  logic [BW-1:0]           r_fifo_instr [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0]   r_fifo_pc [FIFO_DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;

  logic [PW-1:0]           w_fifo_count;
  logic [31:0]             w_inflight;
  logic [31:0]             w_occupancy;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_issue;
  logic                    w_push;
  logic                    w_pop;
  logic [WORD_WIDTH-1:0]   w_head_pc;

  assign w_fifo_count = r_wr_ptr - r_rd_ptr;
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Outstanding work = buffered bundles plus requests still in the imem pipe.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < IMEM_LATENCY; i++) begin
      w_inflight = w_inflight + 32'(r_sr_vld[i]);
    end
    w_occupancy = 32'(w_fifo_count) + w_inflight;
  end

  // Request is gated by rst_in so it drops immediately on an asynchronous reset.
  assign w_issue = rst_in && !redirect_valid_in && (w_occupancy < 32'(FIFO_DEPTH));
  assign w_push  = r_sr_vld[IMEM_LATENCY-1] && !redirect_valid_in && !w_full;
  assign w_pop   = !w_empty && decode_ready_in && !redirect_valid_in;

  assign imem_req_out  = w_issue;
  assign imem_addr_out = r_pc;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid_in) begin
      r_pc <= redirect_pc_in;
    end else if (w_issue) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  // Valid/PC shift register tracking requests until their data returns.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_sr_vld <= '0;
      for (int i = 0; i < IMEM_LATENCY; i++) begin
        r_sr_pc[i] <= '0;
      end
    end else if (redirect_valid_in) begin
      r_sr_vld <= '0;
    end else begin
      r_sr_vld[0] <= w_issue;
      r_sr_pc[0]  <= r_pc;
      for (int i = 1; i < IMEM_LATENCY; i++) begin
        r_sr_vld[i] <= r_sr_vld[i-1];
        r_sr_pc[i]  <= r_sr_pc[i-1];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (redirect_valid_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked solely by the pointers.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr[AW-1:0]] <= imem_data_in;
      r_fifo_pc[r_wr_ptr[AW-1:0]]    <= r_sr_pc[IMEM_LATENCY-1];
    end
  end

  assign decode_valid_out = !w_empty;
  assign decode_instr_out = r_fifo_instr[r_rd_ptr[AW-1:0]];
  assign w_head_pc        = r_fifo_pc[r_rd_ptr[AW-1:0]];

  for (genvar g = 0; g < SUPER_SCALAR_WIDTH; g++) begin : g_slot_pc
    assign decode_pc_out[g*WORD_WIDTH +: WORD_WIDTH] = w_head_pc + WORD_WIDTH'(4 * g);
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_squash;
  logic [32:0] w_squash_sum;

  assign w_squash_sum = {1'b0, r_perf_squash} + 33'(w_occupancy);

  // Saturating counters: decode stall cycles and bundles discarded by redirects.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_perf_stall  <= '0;
      r_perf_squash <= '0;
    end else begin
      if (decode_valid_out && !decode_ready_in && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (redirect_valid_in) begin
        r_perf_squash <= w_squash_sum[32] ? '1 : w_squash_sum[31:0];
      end
    end
  end

  assign perf_stall_cycles_out = r_perf_stall;
  assign perf_squashed_out     = r_perf_squash;
`else
  // Perf counters not built.
`endif

endmodule
